// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with NZCV flag register and flag bypass
//
// Purpose:
//   Registers the ALU result, store data, destination register and the
//   memory/writeback control bits for the MEM stage. Holds the architectural
//   NZCV flags (updated by flag-setting instructions) and provides a
//   combinational flag bypass so the branch unit can resolve B.cond in the
//   same cycle as the flag-setting instruction.
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   stall, flush          - hold all stage state / squash the EX instruction
//   ex_valid              - EX holds a real instruction (0 = bubble)
//   ex_result             - ALU result
//   ex_negative/zero/overflow/carry_out - ALU flag outputs
//   ex_set_flags          - instruction writes NZCV
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg - downstream control
//   ex_rd                 - destination register index
//   ex_store_data         - store data
//   mem_*                 - registered copies of the above for the MEM stage
//   flags_q               - architectural NZCV, bit order {N,Z,C,V}
//   flags_fwd             - bypassed NZCV for the branch unit

module ex_mem_stage #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          REG_ADDR_WIDTH = 5,
  parameter logic [3:0]  FLAGS_RESET    = 4'b0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic                      ex_negative,
  input  logic                      ex_zero,
  input  logic                      ex_overflow,
  input  logic                      ex_carry_out,
  input  logic                      ex_set_flags,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic                      ex_mem_to_reg,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      mem_valid,
  output logic [DATA_WIDTH-1:0]     mem_result,
  output logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic                      mem_reg_write,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic                      mem_mem_to_reg,
  output logic [3:0]                flags_q,
  output logic [3:0]                flags_fwd
);

  localparam logic [REG_ADDR_WIDTH-1:0] XZR = '1;

  logic                      mem_valid_q,      mem_valid_d;
  logic [DATA_WIDTH-1:0]     mem_result_q,     mem_result_d;
  logic [DATA_WIDTH-1:0]     mem_store_data_q, mem_store_data_d;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_q,         mem_rd_d;
  logic                      mem_reg_write_q,  mem_reg_write_d;
  logic                      mem_mem_read_q,   mem_mem_read_d;
  logic                      mem_mem_write_q,  mem_mem_write_d;
  logic                      mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic [3:0]                flags_d;

  logic [3:0] ex_flags;
  logic       ex_flag_live;
  logic       capture;

  assign ex_flags     = {ex_negative, ex_zero, ex_carry_out, ex_overflow};
  // Forwarding ignores stall: a stalled setter is still the youngest producer.
  assign ex_flag_live = ex_valid & ex_set_flags & ~flush;
  assign capture      = ~flush & ~stall;

  always_comb begin
    mem_valid_d      = mem_valid_q;
    mem_result_d     = mem_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_mem_read_d   = mem_mem_read_q;
    mem_mem_write_d  = mem_mem_write_q;
    mem_mem_to_reg_d = mem_mem_to_reg_q;
    flags_d          = flags_q;

    if (flush) begin
      // Squash only what could cause side effects; mem_to_reg, data and rd hold.
      mem_valid_d     = 1'b0;
      mem_reg_write_d = 1'b0;
      mem_mem_read_d  = 1'b0;
      mem_mem_write_d = 1'b0;
    end else if (capture) begin
      mem_valid_d      = ex_valid;
      mem_result_d     = ex_result;
      mem_store_data_d = ex_store_data;
      mem_rd_d         = ex_rd;
      // Writes to X31 are discarded at the source.
      mem_reg_write_d  = ex_valid & ex_reg_write & (ex_rd != XZR);
      // A load/store conflict resolves as a store.
      mem_mem_read_d   = ex_valid & ex_mem_read & ~ex_mem_write;
      mem_mem_write_d  = ex_valid & ex_mem_write;
      mem_mem_to_reg_d = ex_valid & ex_mem_to_reg;
      if (ex_valid & ex_set_flags) begin
        flags_d = ex_flags;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid_q      <= 1'b0;
      mem_result_q     <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      flags_q          <= FLAGS_RESET;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_result_q     <= mem_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      flags_q          <= flags_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_result     = mem_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_read   = mem_mem_read_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign mem_mem_to_reg = mem_mem_to_reg_q;
  assign flags_fwd      = ex_flag_live ? ex_flags : flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, ex_valid;
  logic [63:0] ex_result, ex_store_data;
  logic        ex_negative, ex_zero, ex_overflow, ex_carry_out;
  logic        ex_set_flags, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic [63:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic [3:0]  flags_q, flags_fwd;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .FLAGS_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_result(ex_result), .ex_negative(ex_negative), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_carry_out(ex_carry_out), .ex_set_flags(ex_set_flags),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .flags_q(flags_q), .flags_fwd(flags_fwd)
  );

  typedef struct {
    logic        stall, flush, valid, set_flags, rw, mr, mw, m2r;
    logic [3:0]  nzcv;
    logic [63:0] result, store;
    logic [4:0]  rd;
    logic [3:0]  e_fwd;
    logic        e_valid, e_rw, e_mr, e_mw, e_m2r;
    logic [63:0] e_result, e_store;
    logic [4:0]  e_rd;
    logic [3:0]  e_flags;
  } vec_t;

  vec_t vecs[12];

  // Reference state: what the MEM stage should hold, tracked from the rules.
  logic        m_valid, m_rw, m_mr, m_mw, m_m2r;
  logic [63:0] m_result, m_store;
  logic [4:0]  m_rd;
  logic [3:0]  m_flags;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic sf,
                       input logic [3:0] nzcv, input logic [63:0] res, input logic [63:0] sd,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic m2r);
    stall = st; flush = fl; ex_valid = v; ex_set_flags = sf;
    ex_negative = nzcv[3]; ex_zero = nzcv[2]; ex_carry_out = nzcv[1]; ex_overflow = nzcv[0];
    ex_result = res; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
  endtask

  task automatic check_regs(input string tag, input logic v, input logic [63:0] res,
                            input logic [63:0] sd, input logic [4:0] rd, input logic rw,
                            input logic mr, input logic mw, input logic m2r, input logic [3:0] fl);
    check({tag, ".mem_valid"},      mem_valid,      v);
    check({tag, ".mem_result"},     mem_result,     res);
    check({tag, ".mem_store_data"}, mem_store_data, sd);
    check({tag, ".mem_rd"},         mem_rd,         rd);
    check({tag, ".mem_reg_write"},  mem_reg_write,  rw);
    check({tag, ".mem_mem_read"},   mem_mem_read,   mr);
    check({tag, ".mem_mem_write"},  mem_mem_write,  mw);
    check({tag, ".mem_mem_to_reg"}, mem_mem_to_reg, m2r);
    check({tag, ".flags_q"},        flags_q,        fl);
  endtask

  // Apply one edge of the stage's rules to the reference state.
  task automatic model_edge();
    logic [3:0] live;
    live = {ex_negative, ex_zero, ex_carry_out, ex_overflow};
    if (flush) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    end else if (!stall) begin
      m_valid  = ex_valid;
      m_result = ex_result;
      m_store  = ex_store_data;
      m_rd     = ex_rd;
      m_rw     = ex_valid && ex_reg_write && (ex_rd != 5'd31);
      m_mw     = ex_valid && ex_mem_write;
      m_mr     = ex_valid && ex_mem_read && !(ex_mem_read && ex_mem_write);
      m_m2r    = ex_valid && ex_mem_to_reg;
      if (ex_valid && ex_set_flags) m_flags = live;
    end
  endtask

  function automatic vec_t mk(logic st, logic fl, logic v, logic sf, logic [3:0] nzcv,
                              logic [63:0] res, logic [63:0] sd, logic [4:0] rd,
                              logic rw, logic mr, logic mw, logic m2r, logic [3:0] e_fwd,
                              logic e_v, logic [63:0] e_res, logic [63:0] e_sd, logic [4:0] e_rd,
                              logic e_rw, logic e_mr, logic e_mw, logic e_m2r, logic [3:0] e_fl);
    vec_t t;
    t.stall = st; t.flush = fl; t.valid = v; t.set_flags = sf; t.nzcv = nzcv;
    t.result = res; t.store = sd; t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw; t.m2r = m2r;
    t.e_fwd = e_fwd; t.e_valid = e_v; t.e_result = e_res; t.e_store = e_sd; t.e_rd = e_rd;
    t.e_rw = e_rw; t.e_mr = e_mr; t.e_mw = e_mw; t.e_m2r = e_m2r; t.e_flags = e_fl;
    return t;
  endfunction

  initial begin
    string tag;
    // inputs:  st fl v sf nzcv result stored rd rw mr mw m2r | fwd | valid result store rd rw mr mw m2r flags
    vecs[0]  = mk(0,0,1,1,4'b0110,64'h0,64'h11,5'd3,1,0,0,0, 4'b0110, 1,64'h0,64'h11,5'd3,1,0,0,0,4'b0110);
    vecs[1]  = mk(1,0,1,1,4'b1000,64'h8000_0000_0000_0000,64'h22,5'd4,1,0,0,0, 4'b1000,
                  1,64'h0,64'h11,5'd3,1,0,0,0,4'b0110);
    vecs[2]  = mk(1,0,1,1,4'b1000,64'h8000_0000_0000_0000,64'h22,5'd4,1,0,0,0, 4'b1000,
                  1,64'h0,64'h11,5'd3,1,0,0,0,4'b0110);
    vecs[3]  = mk(0,0,1,1,4'b1000,64'h8000_0000_0000_0000,64'h22,5'd4,1,0,0,0, 4'b1000,
                  1,64'h8000_0000_0000_0000,64'h22,5'd4,1,0,0,0,4'b1000);
    vecs[4]  = mk(1,1,1,1,4'b0101,64'h55,64'h44,5'd7,0,0,1,0, 4'b1000,
                  0,64'h8000_0000_0000_0000,64'h22,5'd4,0,0,0,0,4'b1000);
    vecs[5]  = mk(0,0,1,0,4'b0000,64'h1234,64'h55,5'd31,1,0,0,0, 4'b1000,
                  1,64'h1234,64'h55,5'd31,0,0,0,0,4'b1000);
    vecs[6]  = mk(0,0,1,0,4'b0000,64'h100,64'h66,5'd5,0,1,1,0, 4'b1000,
                  1,64'h100,64'h66,5'd5,0,0,1,0,4'b1000);
    vecs[7]  = mk(0,0,1,1,4'b0011,64'hFFFF,64'h77,5'd6,1,0,0,0, 4'b0011,
                  1,64'hFFFF,64'h77,5'd6,1,0,0,0,4'b0011);
    vecs[8]  = mk(0,0,1,0,4'b1100,64'hF0,64'h88,5'd8,1,0,0,0, 4'b0011,
                  1,64'hF0,64'h88,5'd8,1,0,0,0,4'b0011);
    vecs[9]  = mk(0,0,0,1,4'b1111,64'hAA,64'h99,5'd9,1,1,1,1, 4'b0011,
                  0,64'hAA,64'h99,5'd9,0,0,0,0,4'b0011);
    vecs[10] = mk(0,0,1,0,4'b0000,64'h2000,64'hAA,5'd10,1,1,0,1, 4'b0011,
                  1,64'h2000,64'hAA,5'd10,1,1,0,1,4'b0011);
    vecs[11] = mk(0,1,1,1,4'b1111,64'h3000,64'hBB,5'd11,1,0,0,0, 4'b0011,
                  0,64'h2000,64'hAA,5'd10,0,0,0,1,4'b0011);

    reset = 1'b1;
    drive(1,1,1,1,4'b1111,64'h5,64'h6,5'd1,1,1,1,1);
    @(posedge clk); #1;
    check_regs("reset", 0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 4'b0000);
    reset = 1'b0;

    foreach (vecs[i]) begin
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].set_flags, vecs[i].nzcv,
            vecs[i].result, vecs[i].store, vecs[i].rd, vecs[i].rw, vecs[i].mr,
            vecs[i].mw, vecs[i].m2r);
      #1 check({tag, ".flags_fwd"}, flags_fwd, vecs[i].e_fwd);
      @(posedge clk); #1;
      check_regs(tag, vecs[i].e_valid, vecs[i].e_result, vecs[i].e_store, vecs[i].e_rd,
                 vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_m2r, vecs[i].e_flags);
    end

    // Asynchronous reset in the middle of a cycle with live state.
    drive(0,0,1,1,4'b1010,64'h77,64'h78,5'd2,1,0,0,0);
    @(posedge clk); #1;
    check("pre_reset.mem_valid", mem_valid, 1'b1);
    check("pre_reset.flags_q", flags_q, 4'b1010);
    #2 reset = 1'b1;
    #1 check_regs("async_reset", 0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 4'b0000);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0,0,0,1,4'b1111,64'h0,64'h0,5'd0,1,1,1,1);
    #1 check("post_reset.flags_fwd", flags_fwd, 4'b0000);
    @(posedge clk); #1;
    check_regs("post_reset_bubble", 0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 4'b0000);

    m_valid = 0; m_result = '0; m_store = '0; m_rd = '0;
    m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_flags = 4'b0000;

    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      logic [3:0] exp_fwd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
            1'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, rd,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      exp_fwd = (ex_valid && ex_set_flags && !flush)
                ? {ex_negative, ex_zero, ex_carry_out, ex_overflow} : m_flags;
      #1 check("rand.flags_fwd", flags_fwd, exp_fwd);
      @(posedge clk); #1;
      model_edge();
      check_regs("rand", m_valid, m_result, m_store, m_rd, m_rw, m_mr, m_mw, m_m2r, m_flags);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
